// File: rtl/mapper_reducer.sv
// Snapshots NUM_MAPPERS running match counts on a start pulse and sums them
// one mapper per cycle into a saturated 32-bit total with a valid/ready output.
module mapper_reducer #(
  parameter int unsigned NUM_MAPPERS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [32*NUM_MAPPERS-1:0]   i_counts,
  output logic                        o_busy,
  output logic                        o_total_valid,
  input  logic                        i_total_rdy,
  output logic [31:0]                 o_total,
  output logic                        o_overflow
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MAPPERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    OUT
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   acc;
  logic               ovf;
  logic [CNT_W-1:0]   snap [NUM_MAPPERS];

  logic [CNT_W:0]     sum_c;
  logic [CNT_W-1:0]   next_acc_c;
  logic               next_ovf_c;

  // One 33-bit add per cycle; saturation is sticky for the rest of the run.
  always_comb begin
    sum_c      = {1'b0, acc} + {1'b0, snap[idx]};
    next_ovf_c = ovf | sum_c[CNT_W];
    next_acc_c = next_ovf_c ? '1 : sum_c[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      idx           <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
      for (int k = 0; k < int'(NUM_MAPPERS); k++) snap[k] <= '0;
      o_busy        <= 1'b0;
      o_total_valid <= 1'b0;
      o_total       <= '0;
      o_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            for (int k = 0; k < int'(NUM_MAPPERS); k++)
              snap[k] <= i_counts[CNT_W*k +: CNT_W];
            acc    <= '0;
            ovf    <= 1'b0;
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= SUM;
          end
        end
        SUM: begin
          acc <= next_acc_c;
          ovf <= next_ovf_c;
          if (idx == LAST_IDX) begin
            state         <= OUT;
            o_total_valid <= 1'b1;
            o_total       <= next_acc_c;
            o_overflow    <= next_ovf_c;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        OUT: begin
          // Result is held until the consumer takes it; start is ignored here.
          if (i_total_rdy) begin
            state         <= IDLE;
            o_total_valid <= 1'b0;
            o_busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_reducer.sv
// Randomized self-checking bench for mapper_reducer against a plain-arithmetic
// model of the saturated sum and the start/valid/handshake timing.
module tb_mapper_reducer;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [32*N-1:0] counts;
  logic            busy;
  logic            valid;
  logic            rdy;
  logic [31:0]     total;
  logic            ovf;

  int n_checks = 0;
  int n_errors = 0;

  mapper_reducer #(.NUM_MAPPERS(N)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_counts      (counts),
    .o_busy        (busy),
    .o_total_valid (valid),
    .i_total_rdy   (rdy),
    .o_total       (total),
    .o_overflow    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: unbounded sum, clipped to 32 bits.
  task automatic ref_sum(input logic [31:0] c [N], output logic [31:0] t, output logic o);
    longint unsigned s = 0;
    for (int k = 0; k < int'(N); k++) s += longint'(c[k]);
    o = (s > 64'hFFFF_FFFF);
    t = o ? 32'hFFFF_FFFF : s[31:0];
  endtask

  task automatic drive_counts(input logic [31:0] c [N]);
    for (int k = 0; k < int'(N); k++) counts[32*k +: 32] = c[k];
  endtask

  // One reduction; inputs change and outputs are sampled on negedges.
  task automatic run(input logic [31:0] c [N], input int hold, input bit pulse,
                     input bit change, input logic [31:0] newval);
    logic [31:0] et;
    logic        eo;
    int          lat;
    ref_sum(c, et, eo);
    drive_counts(c);
    start = 1'b1;
    rdy   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (change) for (int k = 0; k < int'(N); k++) counts[32*k +: 32] = newval;
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
      check("busy_in_sum", busy, 1);
    end
    check("latency", lat, N);
    for (int i = 0; i < hold; i++) begin
      check("valid_held", valid, 1);
      check("total", total, et);
      check("overflow", ovf, eo);
      start = (pulse && i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    check("valid_at_hs", valid, 1);
    check("total_at_hs", total, et);
    check("overflow_at_hs", ovf, eo);
    check("busy_at_hs", busy, 1);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("valid_after_hs", valid, 0);
      check("busy_after_hs", busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] c [N];
    int          t0;
    rst    = 1'b1;
    start  = 1'b0;
    rdy    = 1'b0;
    counts = '0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_total", total, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    c = '{32'd1, 32'd2, 32'd3, 32'd4};
    run(c, 0, 0, 0, 0);
    c = '{32'd9, 32'd8, 32'd7, 32'd6};
    run(c, 5, 1, 0, 0);
    c = '{32'hFFFF_FFF0, 32'h20, 32'd0, 32'd5};
    run(c, 1, 0, 0, 0);
    c = '{32'd1, 32'd1, 32'd1, 32'd1};
    run(c, 0, 0, 0, 0);
    c = '{32'd10, 32'd20, 32'd30, 32'd40};
    run(c, 2, 0, 1, 32'd100);

    // Asynchronous reset in the middle of SUM.
    c = '{32'd50, 32'd60, 32'd70, 32'd80};
    drive_counts(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_total", total, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_valid_after_rst", valid, 0);
    end
    c = '{32'd5, 32'd0, 32'd0, 32'd0};
    run(c, 0, 0, 0, 0);

    for (int r = 0; r < 25; r++) begin
      int mode;
      for (int k = 0; k < int'(N); k++) begin
        mode = $urandom_range(0, 2);
        if (mode == 0)      c[k] = 32'($urandom_range(0, 1000));
        else if (mode == 1) c[k] = 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
        else                c[k] = $urandom;
      end
      run(c, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom);
    end

    // Back-to-back: start held high, ready tied high.
    c = '{32'd7, 32'd7, 32'd7, 32'd7};
    drive_counts(c);
    rdy   = 1'b1;
    start = 1'b1;
    t0 = 0;
    while (!valid && t0 < 20) begin
      @(negedge clk);
      t0++;
    end
    check("b2b_first_valid", valid, 1);
    for (int p = 0; p < 4; p++) begin
      check("b2b_valid", valid, 1);
      check("b2b_total", total, 28);
      check("b2b_ovf", ovf, 0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("b2b_gap", valid, 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    rdy   = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mapper_reducer.md
# mapper_reducer

Downstream stage of the word-count mappers in the map-reduce user logic. Takes the running 32-bit match counts of `NUM_MAPPERS` mapper instances and snapshots them all on a start pulse. It sums the snapshot sequentially, one mapper per cycle, and presents a single saturated total to the host-side register/stream logic over a valid/ready handshake.

## Interface
- `NUM_MAPPERS`, default 4: number of mapper count inputs, legal range 1..16.
- `i_clk`  input  1: single clock; all state updates on the rising edge.
- `i_rst`  input  1: reset, asynchronous, active-high.
- `i_start`  input  1: request a reduction; sampled only in IDLE.
- `i_counts`  input  32*NUM_MAPPERS: packed mapper counts; mapper k occupies bits [32k+31:32k].
- `o_busy`  output  1: high whenever state is not IDLE.
- `o_total_valid`  output  1: result available.
- `i_total_rdy`  input  1: consumer accepts the result.
- `o_total`  output  32: summed count, saturated.
- `o_overflow`  output  1: set when the sum saturated; qualified by `o_total_valid`.

## Operation
- States: IDLE, SUM, OUT.
- Reset, asynchronous: state=IDLE, index=0, accumulator=0, snapshot registers=0. Output reset values: `o_busy`=0, `o_total_valid`=0, `o_total`=0, `o_overflow`=0.
- IDLE, `i_start`=1 at an edge:
  - copy all `NUM_MAPPERS` counts into internal snapshot registers on that edge;
  - clear accumulator and overflow flag, set index=0, go to SUM.
- IDLE, `i_start`=0: hold.
- SUM: on each edge, add snapshot[index] to the accumulator, then increment index.
  - Addition is 33-bit. If bit 32 is set, or overflow is already set, the accumulator becomes 32'hFFFFFFFF and overflow sets; both are sticky for this run.
  - After the edge that adds index NUM_MAPPERS-1, go to OUT.
- OUT: `o_total_valid`=1. `o_total` and `o_overflow` are held stable until `o_total_valid & i_total_rdy` at an edge, then the block returns to IDLE.
- After the handshake, `o_total` and `o_overflow` keep their last values; they are only meaningful while valid is high.
- `i_start` is ignored in SUM and OUT; nothing is queued.
- Changes on `i_counts` after the snapshot edge do not affect the in-progress result.
- Reset mid-SUM or mid-OUT abandons the run. No result is emitted.

## Timing
- Edge 0 samples `i_start`. Adds happen on edges 1..NUM_MAPPERS. `o_total_valid` rises after edge NUM_MAPPERS, giving a latency of NUM_MAPPERS cycles.
- A handshake is possible on the first valid cycle. With `i_total_rdy` tied high, valid is high for exactly 1 cycle.
- Minimum start-to-start period is NUM_MAPPERS+2 cycles: one SUM per mapper, one OUT, one IDLE.
- `o_total_valid` never drops without a handshake or reset.
- `o_busy` is high from the cycle after the start edge through the last OUT cycle.
- NUM_MAPPERS=1: a single SUM cycle; valid rises 1 cycle after start.
- The index counter is sized `$clog2(NUM_MAPPERS)`, minimum 1 bit. It never wraps past NUM_MAPPERS-1 within a run.

## Test plan
- Basic sum, NUM_MAPPERS=4: counts 1,2,3,4 and an `i_start` pulse. Required: `o_total_valid` high 4 cycles after the start edge, `o_total`=10, `o_overflow`=0, `o_busy`=1 throughout.
- Backpressure: `i_total_rdy` held low 5 cycles after valid, with an `i_start` pulse during OUT. Required:
  - `o_total` stable and valid held all 5 cycles;
  - the start pulse is ignored;
  - return to IDLE the edge after `i_total_rdy` rises;
  - no second result.
- Saturation: counts 32'hFFFFFFF0, 32'h20, 0, 5. Required: `o_total`=32'hFFFFFFFF, `o_overflow`=1. A next run with counts 1,1,1,1 gives `o_total`=4, `o_overflow`=0.
- Snapshot isolation: counts 10,20,30,40 at start, all changed to 100 the cycle after start. Required: `o_total`=100.
- Reset mid-run: assert `i_rst` asynchronously two cycles into SUM. Required:
  - all outputs 0 immediately, without waiting for a clock edge;
  - valid never rises;
  - after release, a run with counts 5,0,0,0 yields 5.
- Back-to-back: `i_total_rdy` tied high, `i_start` held high, counts constant 7 each. Required: a result of 28 with a 1-cycle valid pulse every 6 cycles.
